// File: rtl/mod_updown_counter.sv
// ---------------------------------------------------------------------------
// mod_updown_counter
//
// Modulo-MOD up/down counter used for every stage of the digital-clock time
// chain (prescaler, seconds, minutes, hours, day-of-month). Stages cascade by
// wiring one stage's carry (or borrow) into the next stage's en.
//
// The modulus sets the count range 0..MOD-1 and the width defaults to the
// minimum needed to hold it. A wrap parameter selects wrapping or saturating
// behaviour at the terminal values, and a digit count sizes the optional BCD
// output, which exists only when MOD_COUNTER_BCD_OUT_EN is defined and is a
// combinational double-dabble conversion of count (digit 0 in bits [3:0]).
//
// The counter advances on rising clock edges and resets asynchronously on a
// low reset. Synchronous clear and load (clamped to the terminal value)
// support time-setting. carry and borrow are registered one-cycle pulses on
// the up-wrap and down-wrap respectively; at_max and at_zero are
// combinational flags derived from count.
//
// Per-edge priority: clear > load > en > hold. carry/borrow are only ever
// set by an enabled wrap, so every other edge returns them to 0.
// ---------------------------------------------------------------------------
module mod_updown_counter #(
   parameter int MOD    = 60,
   parameter int BITS   = $clog2(MOD),
   parameter int WRAP   = 1,
   parameter int DIGITS = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            en,
   input  logic            up,
   input  logic            clear,
   input  logic            load,
   input  logic [BITS-1:0] load_value,
   output logic [BITS-1:0] count,
   output logic            carry,
   output logic            borrow,
   output logic            at_max,
   output logic            at_zero
`ifdef MOD_COUNTER_BCD_OUT_EN
   ,
   output logic [4*DIGITS-1:0] count_bcd
`endif
);

   // Elaboration guard: an illegal parameter set instantiates a module that
   // does not exist, so the build stops instead of producing a bad counter.
   generate
      if (MOD < 2 || BITS < $clog2(MOD) || MOD > 10**DIGITS) begin : g_bad_params
         mod_updown_counter_illegal_parameters u_bad_params ();
      end
   endgenerate

   // All arithmetic runs one bit wider than count. That extra bit lets the
   // increment reach MOD itself (needed when MOD == 2**BITS) and turns the
   // decrement's underflow into a plain borrow bit.
   localparam logic [BITS:0]   MOD_EXT = (BITS+1)'(MOD);
   localparam logic [BITS:0]   MAX_EXT = (BITS+1)'(MOD - 1);
   localparam logic [BITS:0]   ONE_EXT = {{BITS{1'b0}}, 1'b1};
   localparam logic [BITS-1:0] MAX_VAL = BITS'(MOD - 1);

   logic [BITS:0]   count_ext;
   logic [BITS:0]   inc_ext;
   logic [BITS:0]   dec_ext;
   logic [BITS:0]   load_ext;
   logic            inc_wraps;
   logic            dec_wraps;

   logic [BITS-1:0] count_nxt;
   logic            carry_nxt;
   logic            borrow_nxt;

   assign count_ext = {1'b0, count};
   assign inc_ext   = count_ext + ONE_EXT;
   assign dec_ext   = count_ext - ONE_EXT;
   assign load_ext  = {1'b0, load_value};

   // Incrementing MOD-1 lands exactly on MOD; decrementing 0 sets the top bit.
   assign inc_wraps = (inc_ext == MOD_EXT);
   assign dec_wraps = dec_ext[BITS];

   // -------------------------------------------------------------------------
   // Next-state selection
   // -------------------------------------------------------------------------
   always_comb begin
      count_nxt  = count;
      carry_nxt  = 1'b0;
      borrow_nxt = 1'b0;

      if (clear) begin
         count_nxt = '0;
      end else if (load) begin
         // Out-of-range load values clamp to the terminal value; a load never
         // raises carry or borrow.
         if (load_ext > MAX_EXT) begin
            count_nxt = MAX_VAL;
         end else begin
            count_nxt = load_value;
         end
      end else if (en) begin
         if (up) begin
            if (inc_wraps) begin
               if (WRAP != 0) begin
                  count_nxt = '0;
                  carry_nxt = 1'b1;
               end
               // Saturating build: hold at MOD-1 with no pulse.
            end else begin
               count_nxt = inc_ext[BITS-1:0];
            end
         end else begin
            if (dec_wraps) begin
               if (WRAP != 0) begin
                  count_nxt  = MAX_VAL;
                  borrow_nxt = 1'b1;
               end
               // Saturating build: hold at 0 with no pulse.
            end else begin
               count_nxt = dec_ext[BITS-1:0];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers. Asynchronous reset also kills any pending pulse.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         carry  <= 1'b0;
         borrow <= 1'b0;
      end else begin
         count  <= count_nxt;
         carry  <= carry_nxt;
         borrow <= borrow_nxt;
      end
   end

   assign at_max  = (count == MAX_VAL);
   assign at_zero = (count == '0);

`ifdef MOD_COUNTER_BCD_OUT_EN
   // -------------------------------------------------------------------------
   // Double-dabble: shift count in MSB first, adding 3 to any digit >= 5
   // before each shift so the digit carries correctly into the next one.
   // Purely combinational, so it tracks count with zero latency and is all
   // zero while reset holds count at 0.
   // -------------------------------------------------------------------------
   logic [4*DIGITS-1:0] bcd_work;

   always_comb begin
      bcd_work = '0;
      for (int i = BITS - 1; i >= 0; i--) begin
         for (int d = 0; d < DIGITS; d++) begin
            if (bcd_work[4*d +: 4] >= 4'd5) begin
               bcd_work[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
            end
         end
         bcd_work = {bcd_work[4*DIGITS-2:0], count[i]};
      end
   end

   assign count_bcd = bcd_work;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_mod_updown_counter
//
// Three counters share one set of inputs:
//   u_w60 : MOD=60, WRAP=1, BITS=6  (seconds/minutes stage)
//   u_s60 : MOD=60, WRAP=0, BITS=7  (saturating; 7 bits so 75 can be loaded)
//   u_w16 : MOD=16, WRAP=1, BITS=4  (MOD == 2**BITS corner)
// A behavioural model computes each counter's next value with plain modulo
// arithmetic and pushes the expectation into exp_q; every step pops and
// compares against the outputs one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mod_updown_counter;

   // ------------------------------------------------------------------------
   // Clock / reset and shared stimulus
   // ------------------------------------------------------------------------
   logic       clock;
   logic       reset;
   logic       en;
   logic       up;
   logic       clear;
   logic       load;
   logic [6:0] lv;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ------------------------------------------------------------------------
   // DUT outputs
   // ------------------------------------------------------------------------
   logic [5:0] cnt_w60;
   logic [6:0] cnt_s60;
   logic [3:0] cnt_w16;
   logic       o_carry  [3];
   logic       o_borrow [3];
   logic       o_max    [3];
   logic       o_zero   [3];
   logic [6:0] o_cnt    [3];
`ifdef MOD_COUNTER_BCD_OUT_EN
   logic [7:0] o_bcd    [3];
`endif

   assign o_cnt[0] = {1'b0, cnt_w60};
   assign o_cnt[1] = cnt_s60;
   assign o_cnt[2] = {3'b000, cnt_w16};

   mod_updown_counter #(.MOD(60), .BITS(6), .WRAP(1), .DIGITS(2)) u_w60 (
      .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear),
      .load(load), .load_value(lv[5:0]), .count(cnt_w60),
      .carry(o_carry[0]), .borrow(o_borrow[0]),
      .at_max(o_max[0]), .at_zero(o_zero[0])
`ifdef MOD_COUNTER_BCD_OUT_EN
      , .count_bcd(o_bcd[0])
`endif
   );

   mod_updown_counter #(.MOD(60), .BITS(7), .WRAP(0), .DIGITS(2)) u_s60 (
      .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear),
      .load(load), .load_value(lv), .count(cnt_s60),
      .carry(o_carry[1]), .borrow(o_borrow[1]),
      .at_max(o_max[1]), .at_zero(o_zero[1])
`ifdef MOD_COUNTER_BCD_OUT_EN
      , .count_bcd(o_bcd[1])
`endif
   );

   mod_updown_counter #(.MOD(16), .BITS(4), .WRAP(1), .DIGITS(2)) u_w16 (
      .clock(clock), .reset(reset), .en(en), .up(up), .clear(clear),
      .load(load), .load_value(lv[3:0]), .count(cnt_w16),
      .carry(o_carry[2]), .borrow(o_borrow[2]),
      .at_max(o_max[2]), .at_zero(o_zero[2])
`ifdef MOD_COUNTER_BCD_OUT_EN
      , .count_bcd(o_bcd[2])
`endif
   );

   // ------------------------------------------------------------------------
   // Behavioural reference model
   // ------------------------------------------------------------------------
   int m_mod  [3] = '{60, 60, 16};
   int m_wrap [3] = '{1, 0, 1};
   int m_bits [3] = '{6, 7, 4};
   int m_cnt  [3];
   int m_ca   [3];
   int m_bo   [3];

   // Expected entry per counter: {count[6:0], carry, borrow}
   logic [8:0] exp_q[$];

   int n_checks;
   int n_err;
   int n_carry_seen;

   function automatic void push_expect();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({7'(m_cnt[i]), 1'(m_ca[i]), 1'(m_bo[i])});
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_ca[i]  = 0;
         m_bo[i]  = 0;
      end
      push_expect();
   endfunction

   // Outcome of one rising edge, from the counter's rules stated directly.
   function automatic void model_edge();
      int v;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 3; i++) begin
         m_ca[i] = 0;
         m_bo[i] = 0;
         if (clear) begin
            m_cnt[i] = 0;
         end else if (load) begin
            v = int'(lv) % (1 << m_bits[i]);
            m_cnt[i] = (v > m_mod[i] - 1) ? m_mod[i] - 1 : v;
         end else if (en && up) begin
            if (m_cnt[i] < m_mod[i] - 1) begin
               m_cnt[i] = m_cnt[i] + 1;
            end else if (m_wrap[i] != 0) begin
               m_cnt[i] = 0;
               m_ca[i]  = 1;
            end
         end else if (en) begin
            if (m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
            end else if (m_wrap[i] != 0) begin
               m_cnt[i] = m_mod[i] - 1;
               m_bo[i]  = 1;
            end
         end
      end
      push_expect();
   endfunction

   // ------------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------------
   task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, idx, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      logic [8:0] e;
      int         ec;
      for (int i = 0; i < 3; i++) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
            return;
         end
         e  = exp_q.pop_front();
         ec = int'(e[8:2]);
         chk({tag, ".count"},   i, 32'(o_cnt[i]),    32'(ec));
         chk({tag, ".carry"},   i, 32'(o_carry[i]),  32'(e[1]));
         chk({tag, ".borrow"},  i, 32'(o_borrow[i]), 32'(e[0]));
         chk({tag, ".at_max"},  i, 32'(o_max[i]),    32'(ec == m_mod[i] - 1));
         chk({tag, ".at_zero"}, i, 32'(o_zero[i]),   32'(ec == 0));
`ifdef MOD_COUNTER_BCD_OUT_EN
         chk({tag, ".bcd"},     i, 32'(o_bcd[i]),    32'(((ec / 10) << 4) | (ec % 10)));
`endif
      end
   endtask

   // ------------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------------
   task automatic drive(input logic d_en, input logic d_up, input logic d_clear,
                        input logic d_load, input logic [6:0] d_lv);
      en    = d_en;
      up    = d_up;
      clear = d_clear;
      load  = d_load;
      lv    = d_lv;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      check_all(tag);
   endtask

   // ------------------------------------------------------------------------
   // Directed + random sequence
   // ------------------------------------------------------------------------
   initial begin
      n_checks     = 0;
      n_err        = 0;
      n_carry_seen = 0;
      reset        = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);

      // Reset held with en=1: counters must stay at 0.
      #2;
      model_reset();
      check_all("reset_async");
      for (int k = 0; k < 3; k++) step("reset_hold");
      reset = 1'b1;
      model_reset();
      check_all("reset_release");

      // First five enabled up edges from reset.
      for (int k = 0; k < 5; k++) step("up_after_reset");
      chk("count_is_5", 0, 32'(o_cnt[0]), 32'd5);

      // Continuous up count from 0 for 120 edges: two carries on MOD=60.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 7'd0);
      step("clear");
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
      for (int k = 0; k < 120; k++) begin
         step("up_run");
         n_carry_seen += int'(o_carry[0]);
      end
      chk("carry_pulses_120", 0, 32'(n_carry_seen), 32'd2);

      // Down from 0: wrap (borrow) versus saturate (hold).
      drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
      step("clear_dn");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
      step("down_from_zero");
      chk("down_wrap_59", 0, 32'(o_cnt[0]), 32'd59);
      step("down_again");

      // Up from 59: wrap with carry versus saturate at max.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd59);
      step("load_59");
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
      step("up_from_59");
      chk("sat_hold_59", 1, 32'(o_cnt[1]), 32'd59);
      step("up_sat_again");

      // Priority and load clamping.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd30);
      step("clear_over_load");
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd30);
      step("load_30");
      drive(1'b1, 1'b0, 1'b0, 1'b1, 7'd75);
      step("load_75");
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd63);
      step("load_63");
      drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd47);
      step("load_47");

      // Reset between edges at count=59 with an up-wrap pending.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd59);
      step("load_59_pre_reset");
      drive(1'b1, 1'b1, 1'b0, 1'b0, 7'd0);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("reset_midcount");
      step("reset_mid_hold");
      reset = 1'b1;
      for (int k = 0; k < 3; k++) step("resume_after_reset");

      // Random mix of en/up/clear/load.
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 14) == 0),
               7'($urandom_range(0, 127)));
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
